// File: rtl/alu_operand_sequencer.sv
// Operand/function sequencer for the 4-bit lab ALU.
// One debounced key press per step: A, then B+func, then result.
module alu_operand_sequencer #(
    parameter int DATA_W          = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_n,
    input  logic [DATA_W-1:0]   sw_data,
    input  logic [1:0]          sw_func,
    input  logic [2*DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0]   op_a,
    output logic [DATA_W-1:0]   op_b,
    output logic [1:0]          func,
    output logic                alu_valid,
    output logic [2*DATA_W-1:0] result,
    output logic                result_valid,
    output logic [1:0]          state
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        EXEC   = 2'b10,
        SHOW   = 2'b11
    } state_t;

    state_t state_q;
    state_t state_d;

    logic             sync_1;
    logic             key_sync;
    logic             key_db;
    logic             key_db_d;
    logic [CNT_W-1:0] cnt;
    logic             press_evt;

    // Two-flop synchroniser; idles high like the released button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1   <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            sync_1   <= key_n;
            key_sync <= sync_1;
        end
    end

    // Accept a new key level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_db <= 1'b1;
            cnt    <= '0;
        end else if (key_sync != key_db) begin
            if (cnt == CNT_LAST) begin
                key_db <= key_sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    // One-cycle pulse the cycle after the debounced key falls (press only).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_db_d  <= 1'b1;
            press_evt <= 1'b0;
        end else begin
            key_db_d  <= key_db;
            press_evt <= key_db_d & ~key_db;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; EXEC always lasts a single cycle and ignores presses.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD_A: if (press_evt) state_d = LOAD_B;
            LOAD_B: if (press_evt) state_d = EXEC;
            EXEC:   state_d = SHOW;
            SHOW:   if (press_evt) state_d = LOAD_B;
            default: state_d = LOAD_A;
        endcase
    end

    // Registered outputs: operand captures, ALU strobe and result latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a         <= '0;
            op_b         <= '0;
            func         <= '0;
            alu_valid    <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            alu_valid <= (state_d == EXEC);
            unique case (state_q)
                LOAD_A: begin
                    if (press_evt) op_a <= sw_data;
                end
                LOAD_B: begin
                    if (press_evt) begin
                        op_b <= sw_data;
                        func <= sw_func;
                    end
                end
                EXEC: begin
                    result       <= alu_result;
                    result_valid <= 1'b1;
                end
                SHOW: begin
                    if (press_evt) begin
                        op_a         <= sw_data;
                        result_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule
